// File: rtl/cpu_run_ctrl.sv
// Run/step/reset sequencer: debounces two board buttons and produces the CPU reset and clock enable.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
module cpu_run_ctrl #(
   parameter int DEBOUNCE_CYCLES = 65535,
   parameter int RESET_HOLD      = 16,
   parameter int CNT_W           = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn1,
   input  logic        btn2,
   input  logic [31:0] pc,
   input  logic        mem_ready,
   input  logic [31:0] bp_addr,
   output logic        cpu_reset_n,
   output logic        cpu_clk_en,
   output logic        step_mode,
   output logic        bp_hit,
   output logic [2:0]  state_dbg
);

   // state      | meaning
   // S_IDLE     | just out of reset, start a reset sequence
   // S_RST_HOLD | cpu_reset_n held low for RESET_HOLD cycles
   // S_RUN      | free-running, cpu_clk_en high
   // S_STEP_WAIT| single-step mode, waiting for a step press
   // S_STEP_PULSE| one instruction advancing until mem_ready
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RST_HOLD   = 3'd1,
      S_RUN        = 3'd2,
      S_STEP_WAIT  = 3'd3,
      S_STEP_PULSE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD - 1);

   // bit 0 = btn1 (reset/run), bit 1 = btn2 (step)
   logic [1:0]       sync1_q, sync2_q, db_q, press_q;
   logic [CNT_W-1:0] db_cnt_q [2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         db_q    <= 2'b11;
         press_q <= 2'b00;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= {btn2, btn1};
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               db_q[i]     <= ~db_q[i];
               db_cnt_q[i] <= '0;
               // only a released->pressed flip counts as an event
               press_q[i]  <= db_q[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   logic ev_rst, ev_step, bp_trig;
   assign ev_rst  = press_q[0];
   assign ev_step = press_q[1];

   state_t           state_q;
   logic [CNT_W-1:0] hold_q;
   logic             cpu_reset_n_q, cpu_clk_en_q, step_mode_q, bp_hit_q;

`ifdef BREAKPOINT_EN
   assign bp_trig = cpu_clk_en_q & mem_ready & (pc == bp_addr);
`else
   logic unused_bp;
   assign unused_bp = ^{pc, bp_addr};
   assign bp_trig   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         hold_q        <= '0;
         cpu_reset_n_q <= 1'b0;
         cpu_clk_en_q  <= 1'b0;
         step_mode_q   <= 1'b0;
         bp_hit_q      <= 1'b0;
      end else begin
         if (ev_rst || ev_step) bp_hit_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q       <= S_RST_HOLD;
               hold_q        <= HOLD_LOAD;
               cpu_reset_n_q <= 1'b0;
               cpu_clk_en_q  <= 1'b0;
               step_mode_q   <= 1'b0;
            end
            S_RST_HOLD: begin
               if (hold_q == '0) begin
                  state_q       <= S_RUN;
                  cpu_reset_n_q <= 1'b1;
                  cpu_clk_en_q  <= 1'b1;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            S_RUN: begin
               if (ev_rst) begin
                  state_q       <= S_RST_HOLD;
                  hold_q        <= HOLD_LOAD;
                  cpu_reset_n_q <= 1'b0;
                  cpu_clk_en_q  <= 1'b0;
                  step_mode_q   <= 1'b0;
               end else if (ev_step || bp_trig) begin
                  state_q      <= S_STEP_WAIT;
                  cpu_clk_en_q <= 1'b0;
                  step_mode_q  <= 1'b1;
                  if (!ev_step) bp_hit_q <= 1'b1;
               end
            end
            S_STEP_WAIT: begin
               if (ev_rst) begin
                  state_q       <= S_RST_HOLD;
                  hold_q        <= HOLD_LOAD;
                  cpu_reset_n_q <= 1'b0;
                  cpu_clk_en_q  <= 1'b0;
                  step_mode_q   <= 1'b0;
               end else if (ev_step) begin
                  state_q      <= S_STEP_PULSE;
                  cpu_clk_en_q <= 1'b1;
               end
            end
            S_STEP_PULSE: begin
               if (mem_ready) begin
                  state_q      <= S_STEP_WAIT;
                  cpu_clk_en_q <= 1'b0;
               end
            end
            default: begin
               state_q       <= S_IDLE;
               cpu_reset_n_q <= 1'b0;
               cpu_clk_en_q  <= 1'b0;
               step_mode_q   <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_reset_n = cpu_reset_n_q;
   assign cpu_clk_en  = cpu_clk_en_q;
   assign step_mode   = step_mode_q;
   assign bp_hit      = bp_hit_q;
   assign state_dbg   = state_q;

endmodule
